channel_state_estimator: RTL and testbench

Receiver-side counterpart to the two-state AWGN channel: estimates the channel's current SNR state from received samples. Each accepted received sample is compared against the expected clean sample. The block then accumulates squared error over a fixed window and produces a mean-squared-error figure. A debounced hysteresis FSM turns that figure into an estimated state, using the same encoding the channel uses: 8'd21 for good/21 dB, 8'd9 for bad/9 dB. It sits after the channel and before the demodulator, which consumes `est_state` for soft-decision scaling.

---
 rtl/channel_state_estimator.sv | 123 ++++++++++++
 tb/tb_channel_state_estimator.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_state_estimator.sv
// Estimates the channel SNR state from received samples: windowed mean squared error
// against the clean reference, then a debounced hysteresis decision (21 = good, 9 = bad).
module channel_state_estimator #(
   parameter int          WIN_LOG2  = 6,
   parameter logic [31:0] THRESH_HI = 32'd4000,
   parameter logic [31:0] THRESH_LO = 32'd1000,
   parameter int          DEBOUNCE  = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               sample_valid,
   input  logic signed [15:0] rx_sample,
   input  logic signed [15:0] ref_sample,
   output logic [31:0]        mse,
   output logic               window_done,
   output logic [7:0]         est_state,
   output logic               state_valid
);
   localparam int ACC_W = 32 + WIN_LOG2;
   localparam int CNT_W = WIN_LOG2 + 1;
   localparam logic [CNT_W-1:0] WIN_LEN = {1'b1, {WIN_LOG2{1'b0}}};
   localparam logic [3:0] DEB = 4'(DEBOUNCE);

   typedef enum logic {GOOD, BAD} state_t;

   logic [16:0]      err;
   logic [16:0]      err_abs;
   logic [15:0]      err_sat;
   logic             s1_valid;
   logic [15:0]      s1_mag;
   logic [31:0]      sq;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             window_close;
   state_t           state, state_next;
   logic [3:0]       qcnt, qcnt_next;
   logic             valid_next;
   logic             qualify;

   // Sign-extend both operands so the 17-bit difference never wraps.
   always_comb begin
      err     = {rx_sample[15], rx_sample} - {ref_sample[15], ref_sample};
      err_abs = err[16] ? (~err + 17'd1) : err;
      err_sat = err_abs[16] ? 16'hFFFF : err_abs[15:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_mag   <= '0;
      end else if (clear) begin
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= sample_valid;
         if (sample_valid) s1_mag <= err_sat;
      end
   end

   assign sq           = 32'(s1_mag) * 32'(s1_mag);
   assign window_close = (cnt == WIN_LEN);

   // A sample arriving in the close cycle seeds the next window instead of being lost.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc         <= '0;
         cnt         <= '0;
         mse         <= '0;
         window_done <= 1'b0;
      end else if (clear) begin
         acc         <= '0;
         cnt         <= '0;
         window_done <= 1'b0;
      end else begin
         window_done <= window_close;
         if (window_close) begin
            mse <= 32'(acc >> WIN_LOG2);
            acc <= s1_valid ? ACC_W'(sq) : '0;
            cnt <= s1_valid ? CNT_W'(1) : '0;
         end else if (s1_valid) begin
            acc <= acc + ACC_W'(sq);
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= GOOD;
         qcnt        <= '0;
         state_valid <= 1'b0;
      end else begin
         state       <= state_next;
         qcnt        <= qcnt_next;
         state_valid <= valid_next;
      end
   end

   // A clear takes priority over any window result presented in the same cycle.
   always_comb begin
      state_next = state;
      qcnt_next  = qcnt;
      valid_next = state_valid;
      qualify    = 1'b0;
      if (clear) begin
         qcnt_next = '0;
      end else if (window_done) begin
         valid_next = 1'b1;
         qualify    = (state == GOOD) ? (mse > THRESH_HI) : (mse < THRESH_LO);
         if (!qualify) begin
            qcnt_next = '0;
         end else if (qcnt + 4'd1 == DEB) begin
            state_next = (state == GOOD) ? BAD : GOOD;
            qcnt_next  = '0;
         end else begin
            qcnt_next = qcnt + 4'd1;
         end
      end
   end

   assign est_state = (state == GOOD) ? 8'd21 : 8'd9;

endmodule

// File: tb/tb_channel_state_estimator.sv
// Self-checking bench for channel_state_estimator: directed window table, corner sequences
// and randomized traffic checked against a window-level scoreboard model.
module tb_channel_state_estimator;
   localparam int          WIN_LOG2  = 2;
   localparam int          WIN       = 1 << WIN_LOG2;
   localparam logic [31:0] THRESH_HI = 32'd4000;
   localparam logic [31:0] THRESH_LO = 32'd1000;
   localparam int          DEBOUNCE  = 2;

   logic               clk = 1'b0;
   logic               reset;
   logic               clear;
   logic               sample_valid;
   logic signed [15:0] rx_sample;
   logic signed [15:0] ref_sample;
   logic [31:0]        mse;
   logic               window_done;
   logic [7:0]         est_state;
   logic               state_valid;

   always #5 clk = ~clk;

   channel_state_estimator #(
      .WIN_LOG2(WIN_LOG2), .THRESH_HI(THRESH_HI), .THRESH_LO(THRESH_LO), .DEBOUNCE(DEBOUNCE)
   ) dut (
      .clk(clk), .reset(reset), .clear(clear), .sample_valid(sample_valid),
      .rx_sample(rx_sample), .ref_sample(ref_sample), .mse(mse),
      .window_done(window_done), .est_state(est_state), .state_valid(state_valid)
   );

   typedef struct {
      int          due;
      logic [31:0] mse;
   } win_t;

   typedef struct {
      int          e0, e1, e2, e3;
      logic [31:0] exp_mse;
      logic [7:0]  exp_state;
   } vec_t;

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          last_accept = 0;
   win_t        pending[$];
   longint      part_sum;
   int          part_n;
   bit          m_good, m_valid, cur_win;
   int          m_q;
   logic [31:0] m_mse, cur_mse;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic reset_model();
      pending.delete();
      part_sum = 0;
      part_n   = 0;
      m_good   = 1'b1;
      m_q      = 0;
      m_valid  = 1'b0;
      m_mse    = '0;
      cur_win  = 1'b0;
   endtask

   task automatic check_output();
      bit due_now;
      due_now = (pending.size() > 0) && (pending[0].due == cyc);
      check("window_done", window_done, due_now);
      cur_win = due_now;
      if (due_now) begin
         cur_mse = pending[0].mse;
         m_mse   = cur_mse;
         void'(pending.pop_front());
      end
      check("mse", mse, m_mse);
      check("est_state", est_state, m_good ? 8'd21 : 8'd9);
      check("state_valid", state_valid, m_valid);
   endtask

   // Drives one cycle of inputs, advances the model by that cycle, then checks the result.
   task automatic apply_stimulus(input bit v, input int rx, input int rf, input bit clr);
      int d;
      sample_valid = v;
      rx_sample    = 16'(rx);
      ref_sample   = 16'(rf);
      clear        = clr;
      if (cur_win && !clr) begin
         m_valid = 1'b1;
         if (m_good ? (cur_mse > THRESH_HI) : (cur_mse < THRESH_LO)) begin
            m_q++;
            if (m_q == DEBOUNCE) begin
               m_good = !m_good;
               m_q    = 0;
            end
         end else begin
            m_q = 0;
         end
      end
      if (clr) begin
         m_q      = 0;
         part_sum = 0;
         part_n   = 0;
         while (pending.size() > 0 && pending[$].due > cyc) void'(pending.pop_back());
      end else if (v) begin
         d = rx - rf;
         if (d < 0) d = -d;
         if (d > 65535) d = 65535;
         part_sum += longint'(d) * longint'(d);
         part_n++;
         last_accept = cyc;
         if (part_n == WIN) begin
            pending.push_back('{cyc + 3, 32'(part_sum >> WIN_LOG2)});
            part_sum = 0;
            part_n   = 0;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      check_output();
   endtask

   task automatic send_window(input int e0, input int e1, input int e2, input int e3);
      int e[4];
      int rf;
      e = '{e0, e1, e2, e3};
      for (int i = 0; i < 4; i++) begin
         rf = int'($urandom_range(0, 20000)) - 10000;
         apply_stimulus(1'b1, rf + e[i], rf, 1'b0);
      end
   endtask

   task automatic wait_window(input logic [31:0] exp_mse, input logic [7:0] exp_state,
                              input string name);
      int budget;
      budget = 0;
      while (!window_done && budget < 10) begin
         apply_stimulus(1'b0, 0, 0, 1'b0);
         budget++;
      end
      check({name, " done"}, window_done, 1'b1);
      check({name, " latency"}, 64'(cyc - last_accept), 64'd3);
      check({name, " mse"}, mse, exp_mse);
      apply_stimulus(1'b0, 0, 0, 1'b0);
      check({name, " state"}, est_state, exp_state);
      check({name, " state_valid"}, state_valid, 1'b1);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vec_t        vecs[8];
      int          g[8];
      logic [31:0] gap_exp[2];
      logic [31:0] got[2];
      int          n_done;
      int          rf, rx, mode;
      logic [7:0]  held_state;

      vecs[0] = '{ 10,  10,  10, 10, 32'd100,  8'd21};
      vecs[1] = '{100,-100,   0,  0, 32'd5000, 8'd21};
      vecs[2] = '{100,  40, -20,  0, 32'd3000, 8'd21};
      vecs[3] = '{-100,100,   0,  0, 32'd5000, 8'd21};
      vecs[4] = '{100, 100,   0,  0, 32'd5000, 8'd9};
      vecs[5] = '{ 60, -20,   0,  0, 32'd1000, 8'd9};
      vecs[6] = '{ 63,   5,  -1,  1, 32'd999,  8'd9};
      vecs[7] = '{-63,   5,   1,  1, 32'd999,  8'd21};
      g = '{7, -13, 25, 0, -31, 12, 40, -3};

      reset        = 1'b0;
      clear        = 1'b0;
      sample_valid = 1'b0;
      rx_sample    = '0;
      ref_sample   = '0;
      reset_model();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      check_output();

      for (int i = 0; i < 8; i++) begin
         send_window(vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3);
         wait_window(vecs[i].exp_mse, vecs[i].exp_state, $sformatf("vec%0d", i));
      end

      apply_stimulus(1'b1, 32767, -32768, 1'b0);
      apply_stimulus(1'b1, 32767, -32768, 1'b0);
      apply_stimulus(1'b1, -32768, 32767, 1'b0);
      apply_stimulus(1'b1, -32768, 32767, 1'b0);
      wait_window(32'd4294836225, 8'd21, "saturate");

      for (int w = 0; w < 2; w++) begin
         longint s;
         s = 0;
         for (int k = 0; k < 4; k++) s += longint'(g[w*4+k]) * longint'(g[w*4+k]);
         gap_exp[w] = 32'(s / 4);
      end
      for (int pass = 0; pass < 2; pass++) begin
         n_done = 0;
         for (int i = 0; i < 8 + 8 * pass + 6; i++) begin
            if (pass == 1 && i % 2 == 1) apply_stimulus(1'b0, 0, 0, 1'b0);
            else if ((pass == 0 ? i : i / 2) < 8) begin
               rf = int'($urandom_range(0, 2000)) - 1000;
               apply_stimulus(1'b1, rf + g[pass == 0 ? i : i / 2], rf, 1'b0);
            end else apply_stimulus(1'b0, 0, 0, 1'b0);
            if (window_done) begin
               if (n_done < 2) got[n_done] = mse;
               n_done++;
            end
         end
         check($sformatf("gap%0d windows", pass), 64'(n_done), 64'd2);
         check($sformatf("gap%0d mse0", pass), got[0], gap_exp[0]);
         check($sformatf("gap%0d mse1", pass), got[1], gap_exp[1]);
      end

      held_state = m_good ? 8'd21 : 8'd9;
      apply_stimulus(1'b1, 50, 0, 1'b0);
      apply_stimulus(1'b1, 50, 0, 1'b0);
      apply_stimulus(1'b1, 90, 0, 1'b1);
      apply_stimulus(1'b1, 20, 0, 1'b0);
      n_done = 0;
      for (int i = 0; i < 6; i++) begin
         apply_stimulus(1'b0, 0, 0, 1'b0);
         if (window_done) n_done++;
      end
      check("clear no window", 64'(n_done), 64'd0);
      check("clear est held", est_state, held_state);
      apply_stimulus(1'b1, -30, 0, 1'b0);
      apply_stimulus(1'b1, 40, 0, 1'b0);
      apply_stimulus(1'b1, 10, 0, 1'b0);
      wait_window(32'd750, held_state, "after clear");

      send_window(100, 100, 0, 0);
      wait_window(32'd5000, 8'd21, "pre-reset");
      apply_stimulus(1'b1, 500, 0, 1'b0);
      apply_stimulus(1'b1, 500, 0, 1'b0);
      sample_valid = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check("async reset mse", mse, 32'd0);
      check("async reset window_done", window_done, 1'b0);
      check("async reset est", est_state, 8'd21);
      check("async reset state_valid", state_valid, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      reset_model();
      check_output();
      send_window(5, -5, 5, -5);
      wait_window(32'd25, 8'd21, "post-reset");

      for (int i = 0; i < 800; i++) begin
         mode = (i / 64) % 3;
         rf   = int'($urandom_range(0, 2000)) - 1000;
         case (mode)
            0:       rx = rf + int'($urandom_range(0, 80)) - 40;
            1:       rx = rf + int'($urandom_range(0, 400)) - 200;
            default: begin
               rf = int'($urandom_range(0, 65535)) - 32768;
               rx = int'($urandom_range(0, 65535)) - 32768;
            end
         endcase
         apply_stimulus($urandom_range(0, 9) < 7, rx, rf, $urandom_range(0, 49) == 0);
      end
      repeat (8) apply_stimulus(1'b0, 0, 0, 1'b0);
      check("scoreboard drained", 64'(pending.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
